// File: rtl/user_input_m_pkg.sv
// Shared types, time constants and time-arithmetic helpers for the push-button
// front end of the clock (user_input_m).
package user_input_m_pkg;

    typedef logic [16:0] COUNTER_T;
    typedef logic        FLAG_T;

    localparam COUNTER_T COUNTER_MAX = 17'd86399;
    localparam COUNTER_T DAY_TICKS   = 17'd86400;
    localparam COUNTER_T MIN_TICK    = 17'd60;
    localparam COUNTER_T HOUR_TICK   = 17'd3600;

    typedef enum logic [2:0] {
        RUN    = 3'd0,
        T_HOUR = 3'd1,
        T_MIN  = 3'd2,
        A_HOUR = 3'd3,
        A_MIN  = 3'd4
    } state_e;

    // The sum gets an 18th bit so the wrap compare never sees a truncated value.
    function automatic COUNTER_T add_hour(input COUNTER_T t);
        logic [17:0] sum;
        sum = {1'b0, t} + {1'b0, HOUR_TICK};
        if (sum > {1'b0, COUNTER_MAX}) sum = sum - {1'b0, DAY_TICKS};
        return sum[16:0];
    endfunction

    function automatic COUNTER_T add_min(input COUNTER_T t);
        COUNTER_T minute;
        minute = (t % HOUR_TICK) / MIN_TICK;
        if (minute == 17'd59) return t - (HOUR_TICK - MIN_TICK);
        return t + MIN_TICK;
    endfunction

    function automatic COUNTER_T floor_min(input COUNTER_T t);
        return t - (t % MIN_TICK);
    endfunction

endpackage

// File: rtl/user_input_m_if.sv
// Button, timestamp and control bundle between the user-input block and the
// counter/alarm side. The slave modport is the user-input block itself.
interface user_input_m_if;
    import user_input_m_pkg::*;

    logic       btn_mode;
    logic       btn_hour;
    logic       btn_min;
    logic       btn_alarm;
    COUNTER_T   counter_state;
    FLAG_T      set_flag;
    COUNTER_T   set_time;
    FLAG_T      alarm_flag;
    COUNTER_T   alarm_time;
    COUNTER_T   edit_time;
    logic [2:0] mode;

    modport master (
        output btn_mode, btn_hour, btn_min, btn_alarm, counter_state,
        input  set_flag, set_time, alarm_flag, alarm_time, edit_time, mode
    );

    modport slave (
        input  btn_mode, btn_hour, btn_min, btn_alarm, counter_state,
        output set_flag, set_time, alarm_flag, alarm_time, edit_time, mode
    );

endinterface

// File: rtl/user_input_m_debounce.sv
// One push-button channel: 2-flop synchroniser, stability counter and a
// single-cycle press pulse on the accepted 0->1 level change.
module debounce_m #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic press
);

    logic        sync1_q, sync2_q;
    logic        level_q, level_d;
    logic [15:0] cnt_q, cnt_d;
    logic        press_q, press_d;

    // The counter tracks how many consecutive samples disagree with the level.
    always_comb begin
        // NOTE: every _d gets a default first, so no latch can be inferred.
        level_d = level_q;
        cnt_d   = '0;
        press_d = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q >= DEBOUNCE_CYCLES - 16'd1) begin
                level_d = sync2_q;
                press_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values.
            sync1_q <= raw;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/user_input_m.sv
// Mode FSM that turns debounced button presses into time-set and alarm-set
// controls; edits live in a shadow register until committed by the mode button.
module user_input_m
    import user_input_m_pkg::*;
#(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter logic [31:0] IDLE_TIMEOUT    = 32'd500000000
) (
    input  logic          clock,
    input  logic          reset,
    user_input_m_if.slave io
);

    logic mode_ev, hour_ev, min_ev, alarm_ev;

    debounce_m #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
        .clock(clock), .reset(reset), .raw(io.btn_mode),  .press(mode_ev));
    debounce_m #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_hour (
        .clock(clock), .reset(reset), .raw(io.btn_hour),  .press(hour_ev));
    debounce_m #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_min (
        .clock(clock), .reset(reset), .raw(io.btn_min),   .press(min_ev));
    debounce_m #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_alarm (
        .clock(clock), .reset(reset), .raw(io.btn_alarm), .press(alarm_ev));

    state_e      state_q, state_d;
    COUNTER_T    shadow_q, shadow_d;
    FLAG_T       set_flag_q, set_flag_d;
    COUNTER_T    set_time_q, set_time_d;
    FLAG_T       alarm_flag_q, alarm_flag_d;
    COUNTER_T    alarm_time_q, alarm_time_d;
    logic [31:0] idle_q, idle_d;

    logic     in_edit;
    logic     any_ev;
    COUNTER_T adjusted;

    assign in_edit = (state_q != RUN);
    assign any_ev  = mode_ev | hour_ev | min_ev | alarm_ev;

    always_comb begin
        state_d      = state_q;
        shadow_d     = shadow_q;
        set_flag_d   = 1'b0;
        set_time_d   = set_time_q;
        alarm_flag_d = alarm_flag_q;
        alarm_time_d = alarm_time_q;
        idle_d       = idle_q;

        // Hour is applied before minute when both arrive together.
        adjusted = shadow_q;
        if (hour_ev) adjusted = add_hour(adjusted);
        if (min_ev)  adjusted = add_min(adjusted);

        if (mode_ev) begin
            unique case (state_q)
                RUN: begin
                    shadow_d = floor_min(io.counter_state);
                    state_d  = T_HOUR;
                end
                T_HOUR: state_d = T_MIN;
                T_MIN: begin
                    set_flag_d = 1'b1;
                    set_time_d = shadow_q;
                    shadow_d   = alarm_time_q;
                    state_d    = A_HOUR;
                end
                A_HOUR: state_d = A_MIN;
                A_MIN: begin
                    alarm_time_d = shadow_q;
                    state_d      = RUN;
                end
                default: state_d = RUN;
            endcase
        end else if (in_edit) begin
            shadow_d = adjusted;
        end

        if (alarm_ev && !in_edit) alarm_flag_d = ~alarm_flag_q;

        // An abandoned edit leaves set_time and alarm_time untouched.
        if (any_ev || !in_edit) begin
            idle_d = '0;
        end else if (idle_q >= IDLE_TIMEOUT - 32'd1) begin
            idle_d   = '0;
            state_d  = RUN;
            shadow_d = '0;
        end else begin
            idle_d = idle_q + 32'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= RUN;
            shadow_q     <= '0;
            set_flag_q   <= 1'b0;
            set_time_q   <= '0;
            alarm_flag_q <= 1'b0;
            alarm_time_q <= '0;
            idle_q       <= '0;
        end else begin
            state_q      <= state_d;
            shadow_q     <= shadow_d;
            set_flag_q   <= set_flag_d;
            set_time_q   <= set_time_d;
            alarm_flag_q <= alarm_flag_d;
            alarm_time_q <= alarm_time_d;
            idle_q       <= idle_d;
        end
    end

    assign io.set_flag   = set_flag_q;
    assign io.set_time   = set_time_q;
    assign io.alarm_flag = alarm_flag_q;
    assign io.alarm_time = alarm_time_q;
    assign io.edit_time  = in_edit ? shadow_q : io.counter_state;
    assign io.mode       = state_q;

endmodule
